// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared state type and index-width helper for the PC redirect unit
package pc_redirect_unit_pkg;
  typedef enum logic {RUN, HOLD} state_t;
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: fetch/redirect bus (stall, req, target in; pc, flush, pend, last_src, redirect_cnt out)
interface pc_redirect_unit_if
  import pc_redirect_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int CNT_W = 16
);
  localparam int SW = idx_w(NSRC);
  logic                  stall;
  logic [NSRC-1:0]       req;
  logic [NSRC*WIDTH-1:0] target;
  logic [WIDTH-1:0]      pc;
  logic                  flush;
  logic                  pend;
  logic [SW-1:0]         last_src;
  logic [CNT_W-1:0]      redirect_cnt;
  modport master (output stall, req, target, input pc, flush, pend, last_src, redirect_cnt);
  modport slave  (input stall, req, target, output pc, flush, pend, last_src, redirect_cnt);
endinterface

// File: rtl/pc_redirect_unit_prio_enc_n.sv
// prio_enc_n: fixed-priority encoder (req in; idx of lowest set bit, valid out)
module prio_enc_n
  import pc_redirect_unit_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  output logic [idx_w(N)-1:0]  idx,
  output logic                 valid
);
  localparam int W = idx_w(N);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: registered PC with prioritised redirects, stall hold, flush pulse and redirect count (clk, reset, bus)
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter int              NSRC     = 4,
  parameter int              INCR     = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  pc_redirect_unit_if.slave bus
);
  localparam int SW = idx_w(NSRC);
  state_t           state;
  logic [WIDTH-1:0] hold_tgt, win_tgt, tgt_ch;
  logic [SW-1:0]    hold_src, win, src_ch;
  logic             any, upd, apply;
  prio_enc_n #(.N(NSRC)) u_enc (.req(bus.req), .idx(win), .valid(any));
  assign win_tgt = bus.target[win*WIDTH +: WIDTH];
  assign upd     = any && (state == RUN || win < hold_src);
  assign apply   = !bus.stall && (state == HOLD || any);
  assign src_ch  = (state == HOLD && !upd) ? hold_src : win;
  assign tgt_ch  = (state == HOLD && !upd) ? hold_tgt : win_tgt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      bus.pc           <= RESET_PC;
      bus.flush        <= 1'b0;
      bus.pend         <= 1'b0;
      bus.last_src     <= '0;
      bus.redirect_cnt <= '0;
      hold_tgt         <= '0;
      hold_src         <= '0;
    end else begin
      bus.flush <= apply;
      if (apply) begin
        bus.pc           <= tgt_ch;
        bus.last_src     <= src_ch;
        bus.redirect_cnt <= (&bus.redirect_cnt) ? bus.redirect_cnt : bus.redirect_cnt + 1'b1;
        bus.pend         <= 1'b0;
        state            <= RUN;
      end else if (!bus.stall) begin
        bus.pc <= bus.pc + WIDTH'(INCR);
      end
      if (bus.stall && upd) begin
        hold_tgt <= win_tgt;
        hold_src <= win;
        bus.pend <= 1'b1;
        state    <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pc_redirect_unit_if #(.WIDTH(32), .NSRC(4), .CNT_W(16)) bus ();
  pc_redirect_unit_if #(.WIDTH(32), .NSRC(1), .CNT_W(2)) bus2 ();
  pc_redirect_unit #(.WIDTH(32), .NSRC(4), .INCR(2), .RESET_PC(32'h0), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  pc_redirect_unit #(.WIDTH(32), .NSRC(1), .INCR(2), .RESET_PC(32'h0), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0; bus.req = '0; bus.target = '0;
    bus2.stall = 1'b0; bus2.req = '0; bus2.target = '0;
    step(); step();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0); end
    checks++; if ({bus.flush, bus.pend} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {bus.flush, bus.pend}); end
    checks++; if (bus.redirect_cnt !== 16'd0 || bus.last_src !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.redirect_cnt, bus.last_src); end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (bus.pc !== 32'(2 * i)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, bus.pc, 32'(2 * i)); end
      checks++; if (bus.flush !== 1'b0 || bus.redirect_cnt !== 16'd0) begin errors++; $display("FAIL seq_flags%0d got %b/%0d exp 0/0", i, bus.flush, bus.redirect_cnt); end
    end
  endtask

  task automatic test_redirect();
    bus.req = 4'b0110;
    bus.target[32 +: 32] = 32'h100;
    bus.target[64 +: 32] = 32'h200;
    step();
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL redir_pc got %h exp %h", bus.pc, 32'h100); end
    checks++; if (bus.last_src !== 2'd1 || bus.flush !== 1'b1) begin errors++; $display("FAIL redir_src_flush got %0d/%b exp 1/1", bus.last_src, bus.flush); end
    checks++; if (bus.redirect_cnt !== 16'd1) begin errors++; $display("FAIL redir_cnt got %0d exp 1", bus.redirect_cnt); end
    bus.req = '0;
    step();
    checks++; if (bus.pc !== 32'h102 || bus.flush !== 1'b0) begin errors++; $display("FAIL redir_after got %h/%b exp 102/0", bus.pc, bus.flush); end
  endtask

  task automatic test_hold();
    logic [3:0] seq [4];
    seq = '{4'b1000, 4'b0000, 4'b0010, 4'b0100};
    bus.target[96 +: 32] = 32'h300;
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req = seq[i];
      step();
      checks++; if (bus.pend !== 1'b1 || bus.pc !== 32'h102 || bus.flush !== 1'b0) begin errors++; $display("FAIL hold%0d got pend=%b pc=%h flush=%b exp 1/102/0", i, bus.pend, bus.pc, bus.flush); end
    end
    bus.stall = 1'b0; bus.req = '0;
    step();
    checks++; if (bus.pc !== 32'h100 || bus.last_src !== 2'd1) begin errors++; $display("FAIL hold_apply got %h/%0d exp 100/1", bus.pc, bus.last_src); end
    checks++; if (bus.flush !== 1'b1 || bus.pend !== 1'b0 || bus.redirect_cnt !== 16'd2) begin errors++; $display("FAIL hold_flags got %b/%b/%0d exp 1/0/2", bus.flush, bus.pend, bus.redirect_cnt); end
    step();
    checks++; if (bus.flush !== 1'b0 || bus.pc !== 32'h102) begin errors++; $display("FAIL hold_after got %b/%h exp 0/102", bus.flush, bus.pc); end
  endtask

  task automatic test_preempt();
    bus.stall = 1'b1; bus.req = 4'b0100;
    step();
    checks++; if (bus.pend !== 1'b1) begin errors++; $display("FAIL pre_pend got %b exp 1", bus.pend); end
    bus.stall = 1'b0; bus.req = 4'b0001; bus.target[0 +: 32] = 32'h40;
    step();
    checks++; if (bus.pc !== 32'h40 || bus.last_src !== 2'd0) begin errors++; $display("FAIL pre_pc got %h/%0d exp 40/0", bus.pc, bus.last_src); end
    checks++; if (bus.redirect_cnt !== 16'd3 || bus.pend !== 1'b0) begin errors++; $display("FAIL pre_cnt got %0d/%b exp 3/0", bus.redirect_cnt, bus.pend); end
    bus.req = '0;
    step();
    checks++; if (bus.pc !== 32'h42 || bus.flush !== 1'b0 || bus.redirect_cnt !== 16'd3) begin errors++; $display("FAIL pre_after got %h/%b/%0d exp 42/0/3", bus.pc, bus.flush, bus.redirect_cnt); end
  endtask

  task automatic test_wrap();
    bus.req = 4'b0001; bus.target[0 +: 32] = 32'hFFFF_FFFE;
    step();
    checks++; if (bus.pc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_load got %h exp fffffffe", bus.pc); end
    bus.req = '0;
    step();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap got %h exp 0", bus.pc); end
  endtask

  task automatic test_reset_hold();
    bus.stall = 1'b1; bus.req = 4'b0100;
    step();
    checks++; if (bus.pend !== 1'b1) begin errors++; $display("FAIL rh_pend got %b exp 1", bus.pend); end
    reset = 1'b1;
    step();
    checks++; if (bus.pc !== 32'h0 || bus.pend !== 1'b0 || bus.redirect_cnt !== 16'd0) begin errors++; $display("FAIL rh_reset got %h/%b/%0d exp 0/0/0", bus.pc, bus.pend, bus.redirect_cnt); end
    reset = 1'b0; bus.stall = 1'b0; bus.req = '0;
    step();
    checks++; if (bus.pc !== 32'h2 || bus.flush !== 1'b0 || bus.redirect_cnt !== 16'd0) begin errors++; $display("FAIL rh_after got %h/%b/%0d exp 2/0/0", bus.pc, bus.flush, bus.redirect_cnt); end
  endtask

  task automatic test_back_to_back_sat();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bus2.req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.target = 32'(32'h10 + 32'(i) * 32'h10);
      step();
      checks++; if (bus2.redirect_cnt !== exp_cnt[i]) begin errors++; $display("FAIL sat%0d got %0d exp %0d", i, bus2.redirect_cnt, exp_cnt[i]); end
      checks++; if (bus2.flush !== 1'b1 || bus2.pc !== 32'(32'h10 + 32'(i) * 32'h10) || bus2.last_src !== 1'b0) begin errors++; $display("FAIL b2b%0d got flush=%b pc=%h exp 1/%h", i, bus2.flush, bus2.pc, 32'(32'h10 + 32'(i) * 32'h10)); end
    end
    bus2.req = 1'b0;
    step();
    checks++; if (bus2.flush !== 1'b0 || bus2.redirect_cnt !== 2'd3) begin errors++; $display("FAIL sat_after got %b/%0d exp 0/3", bus2.flush, bus2.redirect_cnt); end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_hold();
    test_preempt();
    test_wrap();
    test_reset_hold();
    test_back_to_back_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
